// File: rtl/conv_out_framer.sv
// Output framer for the convolution array: drops warm-up samples, scales/saturates
// accumulator results, buffers them and emits a row/col/SOL/EOL/EOF tagged pixel stream.
module conv_out_framer #(
  parameter  int unsigned IMG_W      = 100,
  parameter  int unsigned IMG_H      = 100,
  parameter  int unsigned K          = 3,
  parameter  int unsigned DIN_W      = 20,
  parameter  int unsigned DOUT_W     = 8,
  parameter  int unsigned SHIFT      = 0,
  parameter  int unsigned SIGNED     = 1,
  parameter  int unsigned WARMUP     = 11,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned OUT_W      = IMG_W - K + 1,
  localparam int unsigned OUT_H      = IMG_H - K + 1,
  localparam int unsigned COL_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int unsigned ROW_W      = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DIN_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] out_data,
  output logic [COL_W-1:0]  out_col,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [DIN_W:0] SAT_MAX = {{(DIN_W + 1 - DOUT_W){1'b0}}, {DOUT_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_CAP, S_DRAIN} state_t;

  state_t              state;
  logic [WCNT_W-1:0]   warm_cnt;
  logic [COL_W-1:0]    cap_col;
  logic [ROW_W-1:0]    cap_row;
  logic [DOUT_W-1:0]   mem_data [FIFO_DEPTH];
  logic [COL_W-1:0]    mem_col  [FIFO_DEPTH];
  logic [ROW_W-1:0]    mem_row  [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic                pop_c;
  logic                capture_c;
  logic                push_c;
  logic                last_c;
  logic [CNT_W-1:0]    count_nx_c;
  logic signed [DIN_W:0] ext_c;
  logic signed [DIN_W:0] shr_c;
  logic [DOUT_W-1:0]   scaled_c;

  // Sign/zero extend one bit so a single arithmetic shift serves both modes
  always_comb begin
    ext_c    = (SIGNED != 0) ? $signed({in_data[DIN_W-1], in_data})
                             : $signed({1'b0, in_data});
    shr_c    = ext_c >>> SHIFT;
    scaled_c = shr_c[DOUT_W-1:0];
    if (shr_c[DIN_W])
      scaled_c = '0;
    else if (shr_c > $signed(SAT_MAX))
      scaled_c = '1;
  end

  // Dropped samples still consume a coordinate, so tags travel with the data
  always_comb begin
    pop_c      = out_valid && out_ready;
    capture_c  = (state == S_CAP) && in_valid;
    push_c     = capture_c && ((count != CNT_W'(FIFO_DEPTH)) || pop_c);
    last_c     = (cap_col == COL_W'(OUT_W - 1)) && (cap_row == ROW_W'(OUT_H - 1));
    count_nx_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  assign out_data = mem_data[rd_ptr];
  assign out_col  = mem_col[rd_ptr];
  assign out_row  = mem_row[rd_ptr];
  assign out_sol  = out_valid && (out_col == '0);
  assign out_eol  = out_valid && (out_col == COL_W'(OUT_W - 1));
  assign out_eof  = out_eol && (out_row == ROW_W'(OUT_H - 1));
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      warm_cnt   <= '0;
      cap_col    <= '0;
      cap_row    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      frame_cnt  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_col[i]  <= '0;
        mem_row[i]  <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      if (push_c) begin
        mem_data[wr_ptr] <= scaled_c;
        mem_col[wr_ptr]  <= cap_col;
        mem_row[wr_ptr]  <= cap_row;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop_c)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nx_c;
      out_valid <= (count_nx_c != '0);
      if (capture_c && !push_c)
        overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            warm_cnt <= '0;
            cap_col  <= '0;
            cap_row  <= '0;
            state    <= (WARMUP == 0) ? S_CAP : S_WARM;
          end
        end
        S_WARM: begin
          if (in_valid) begin
            if (warm_cnt == WCNT_W'(WARMUP - 1))
              state <= S_CAP;
            else
              warm_cnt <= warm_cnt + WCNT_W'(1);
          end
        end
        S_CAP: begin
          if (in_valid) begin
            if (last_c) begin
              cap_col <= '0;
              cap_row <= '0;
              state   <= S_DRAIN;
            end else if (cap_col == COL_W'(OUT_W - 1)) begin
              cap_col <= '0;
              cap_row <= cap_row + ROW_W'(1);
            end else begin
              cap_col <= cap_col + COL_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if ((count == '0) || ((count == CNT_W'(1)) && pop_c)) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_framer.sv
// Directed bench for conv_out_framer: a default 100x100 instance and a 5x4, WARMUP=0, SHIFT=2 instance.
module tb_conv_out_framer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters (98x98 output, SHIFT=0, WARMUP=11)
  logic        a_rst, a_start, a_iv, a_or;
  logic [19:0] a_din;
  logic        a_ov, a_sol, a_eol, a_eof, a_busy, a_done, a_ovf;
  logic [7:0]  a_od;
  logic [6:0]  a_col, a_row;
  logic [15:0] a_fcnt;

  conv_out_framer u_a (
    .clock(clock), .reset(a_rst), .start(a_start), .in_valid(a_iv), .in_data(a_din),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_col(a_col), .out_row(a_row),
    .out_sol(a_sol), .out_eol(a_eol), .out_eof(a_eof), .busy(a_busy),
    .frame_done(a_done), .overflow(a_ovf), .frame_cnt(a_fcnt)
  );

  // Instance B: 5x4 image, K=3 -> 3x2 output, no warm-up, SHIFT=2
  logic        b_rst, b_start, b_iv, b_or;
  logic [19:0] b_din;
  logic        b_ov, b_sol, b_eol, b_eof, b_busy, b_done, b_ovf;
  logic [7:0]  b_od;
  logic [1:0]  b_col;
  logic [0:0]  b_row;
  logic [15:0] b_fcnt;

  conv_out_framer #(.IMG_W(5), .IMG_H(4), .K(3), .SHIFT(2), .WARMUP(0)) u_b (
    .clock(clock), .reset(b_rst), .start(b_start), .in_valid(b_iv), .in_data(b_din),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_col(b_col), .out_row(b_row),
    .out_sol(b_sol), .out_eol(b_eol), .out_eof(b_eof), .busy(b_busy),
    .frame_done(b_done), .overflow(b_ovf), .frame_cnt(b_fcnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [6:0] col;
    logic [6:0] row;
    logic       sol;
    logic       eol;
    logic       eof;
  } pix_a_t;

  typedef struct {
    logic [19:0] din;
    logic [7:0]  dout;
  } vec_t;

  pix_a_t a_q[$];
  pix_a_t a_exp, a_act;
  int     a_pops  = 0;
  int     a_dones = 0;
  vec_t   tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int a_val(input int mode, input int i);
    if (mode == 1 && i == 0) return -5;
    if (mode == 1 && i == 1) return 300;
    if (mode == 1 && i == 2) return 128;
    return i;
  endfunction

  function automatic pix_a_t exp_a(input int i, input int v);
    pix_a_t p;
    p.data = (v < 0) ? 8'd0 : (v > 255) ? 8'd255 : 8'(v);
    p.col  = 7'(i % 98);
    p.row  = 7'(i / 98);
    p.sol  = (i % 98) == 0;
    p.eol  = (i % 98) == 97;
    p.eof  = (i == 9603);
    return p;
  endfunction

  function automatic logic [13:0] b_exp(input logic [7:0] d, input int j);
    return {1'b1, d, 2'(j % 3), 1'(j / 3), (j % 3) == 0, (j % 3) == 2, j == 5};
  endfunction

  function automatic logic [13:0] b_act();
    return {b_ov, b_od, b_col, b_row, b_sol, b_eol, b_eof};
  endfunction

  // Scoreboard for instance A: every handshake must match the next expected pixel
  always @(negedge clock) begin
    if (a_done) a_dones++;
    if (a_ov && a_or) begin
      a_pops++;
      checks++;
      a_act = {a_od, a_col, a_row, a_sol, a_eol, a_eof};
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_pop: unexpected pixel %0h, none expected", a_act);
      end else begin
        a_exp = a_q.pop_front();
        if (a_act !== a_exp) begin
          errors++;
          $display("FAIL a_pop %0d: got %0h expected %0h", a_pops, a_act, a_exp);
        end
      end
    end
  end

  task automatic run_a(input int mode, input int n);
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    for (int w = 0; w < 11; w++) begin
      a_iv  = 1'b1;
      a_din = 20'h7FFFF;
      @(negedge clock);
    end
    for (int i = 0; i < n; i++) begin
      if (i % 7 == 3) begin
        a_iv = 1'b0;
        @(negedge clock);
      end
      a_iv  = 1'b1;
      a_din = 20'(a_val(mode, i));
      a_q.push_back(exp_a(i, a_val(mode, i)));
      @(negedge clock);
    end
    a_iv = 1'b0;
  endtask

  task automatic wait_a_idle();
    for (int t = 0; t < 50 && a_busy; t++) @(negedge clock);
    @(negedge clock);
    chk("a_idle_timeout", 64'(a_busy), 64'd0);
  endtask

  initial begin
    a_rst = 1'b0; a_start = 1'b0; a_iv = 1'b0; a_din = '0; a_or = 1'b1;
    b_rst = 1'b0; b_start = 1'b0; b_iv = 1'b0; b_din = '0; b_or = 1'b1;
    tbl[0] = '{20'd1020,   8'd255};
    tbl[1] = '{20'd400,    8'd100};
    tbl[2] = '{20'hFFFFB,  8'd0};
    tbl[3] = '{20'd12,     8'd3};
    tbl[4] = '{20'h80000,  8'd0};
    tbl[5] = '{20'd2000,   8'd255};
    #1;
    chk("reset_a_outputs", {a_ov, a_od, a_sol, a_eol, a_eof, a_busy, a_done, a_ovf, a_fcnt}, 64'd0);
    chk("reset_b_outputs", {b_ov, b_od, b_sol, b_eol, b_eof, b_busy, b_done, b_ovf, b_fcnt}, 64'd0);
    repeat (2) @(negedge clock);
    a_rst = 1'b1;
    b_rst = 1'b1;
    @(negedge clock);

    // Instance B frame 1: table of scaling vectors, start pulse mid-frame ignored
    b_start = 1'b1;
    @(negedge clock);
    for (int j = 0; j < 6; j++) begin
      b_start = (j == 2);
      b_iv    = 1'b1;
      b_din   = tbl[j].din;
      @(negedge clock);
      chk($sformatf("b_tbl%0d", j), b_act(), b_exp(tbl[j].dout, j));
    end
    b_iv = 1'b0; b_start = 1'b0;
    @(negedge clock);
    chk("b_f1_done", {b_done, b_ov, b_busy, b_fcnt}, {1'b1, 1'b0, 1'b0, 16'd1});
    b_iv = 1'b1; b_din = 20'd400;
    @(negedge clock);
    chk("b_idle_ignore", {b_done, b_ov, b_busy}, 64'd0);

    // Instance B frame 2: full FIFO with simultaneous push and pop
    b_iv = 1'b0; b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0; b_or = 1'b0;
    for (int j = 0; j < 4; j++) begin
      b_iv = 1'b1; b_din = 20'(40 + 4 * j);
      @(negedge clock);
    end
    chk("b_full_head", b_act(), b_exp(8'd10, 0));
    b_din = 20'd56; b_or = 1'b1;
    @(negedge clock);
    chk("b_pushpop1", b_act(), b_exp(8'd11, 1));
    b_din = 20'd60;
    @(negedge clock);
    chk("b_pushpop2", b_act(), b_exp(8'd12, 2));
    chk("b_no_ovf", {b_ovf, b_busy}, {1'b0, 1'b1});
    b_iv = 1'b0; b_or = 1'b0;
    @(negedge clock);
    chk("b_stall_hold", b_act(), b_exp(8'd12, 2));
    b_or = 1'b1;
    for (int k = 2; k < 6; k++) begin
      chk($sformatf("b_drain%0d", k), b_act(), b_exp(8'(10 + k), k));
      @(negedge clock);
    end
    chk("b_f2_done", {b_done, b_ov, b_ovf, b_fcnt}, {1'b1, 1'b0, 1'b0, 16'd2});

    // Instance B frame 3: fifth sample dropped, framing kept, overflow sticky
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0; b_or = 1'b0;
    for (int j = 0; j < 5; j++) begin
      b_iv = 1'b1; b_din = 20'(80 + 4 * j);
      @(negedge clock);
    end
    chk("b_ovf_set", 64'(b_ovf), 64'd1);
    chk("b_ovf_head", b_act(), b_exp(8'd20, 0));
    b_din = 20'd100; b_or = 1'b1;
    @(negedge clock);
    b_iv = 1'b0;
    chk("b_drop_p1", b_act(), b_exp(8'd21, 1));
    @(negedge clock);
    chk("b_drop_p2", b_act(), b_exp(8'd22, 2));
    @(negedge clock);
    chk("b_drop_p3", b_act(), b_exp(8'd23, 3));
    @(negedge clock);
    chk("b_drop_eof", b_act(), b_exp(8'd25, 5));
    @(negedge clock);
    chk("b_f3_done", {b_done, b_ov, b_ovf, b_fcnt}, {1'b1, 1'b0, 1'b1, 16'd3});

    // Instance A: full ramp frame
    run_a(0, 9604);
    wait_a_idle();
    chk("a_f1_counts", {32'(a_pops), 16'(a_dones), a_fcnt}, {32'd9604, 16'd1, 16'd1});
    chk("a_f1_state", {a_ovf, 32'(a_q.size())}, 64'd0);

    // Instance A: saturation patterns, then reset mid-frame
    run_a(1, 5000);
    a_rst = 1'b0;
    #1;
    chk("a_async_reset", {a_ov, a_busy, a_done, a_fcnt}, 64'd0);
    a_q.delete();
    @(negedge clock);
    a_rst = 1'b1;
    a_pops = 0;
    a_dones = 0;
    @(negedge clock);
    run_a(0, 9604);
    wait_a_idle();
    chk("a_f3_counts", {32'(a_pops), 16'(a_dones), a_fcnt}, {32'd9604, 16'd1, 16'd1});
    chk("a_f3_state", {a_ovf, 32'(a_q.size())}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
